// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch/decode controller.
// Opcodes, FSM states, ALU selects and instruction field positions.
package instr_fetch_pkg;

    localparam int OP_HI = 6;
    localparam int OP_LO = 4;
    localparam int RD_HI = 3;
    localparam int RS_HI = 1;

    typedef enum logic [2:0] {
        OP_NOOP  = 3'b000,
        OP_STORE = 3'b001,
        OP_LOAD  = 3'b010,
        OP_ADD   = 3'b011,
        OP_SUB   = 3'b100,
        OP_HALT  = 3'b101,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } opcode_t;

    // The five execute states share S_EXEC; the IR opcode selects which one.
    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_WAIT   = 3'd1,
        S_FETCH  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SUB  = 2'b10
    } alu_sel_t;

    function automatic opcode_t op_of(input logic [6:0] w);
        return opcode_t'(w[OP_HI:OP_LO]);
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// ROM bus and datapath control bundle of the fetch controller.
// master = controller side, slave = ROM/datapath side.
interface instr_fetch_ctrl_if #(parameter int PC_W = 7);

    logic [6:0]      Instr;
    logic [PC_W-1:0] PC;
    logic [6:0]      IR;
    logic            RF_W_en;
    logic [1:0]      RF_W_addr;
    logic [1:0]      RF_Ra_addr;
    logic [1:0]      RF_Rb_addr;
    logic            RF_s;
    logic [1:0]      ALU_s;
    logic [3:0]      D_Addr;
    logic            D_Wr;
    logic            Halted;
    logic [2:0]      State;

    modport master (
        input  Instr,
        output PC, IR, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr,
        output RF_s, ALU_s, D_Addr, D_Wr, Halted, State
    );

    modport slave (
        output Instr,
        input  PC, IR, RF_W_en, RF_W_addr, RF_Ra_addr, RF_Rb_addr,
        input  RF_s, ALU_s, D_Addr, D_Wr, Halted, State
    );

endinterface

// File: rtl/instr_fetch_ctrl_pc_counter.sv
// Program counter with synchronous active-low clear.
// Increments by one when inc is high, wrapping naturally at 2**PC_W.
module pc_counter #(
    parameter int PC_W = 7
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    // Clear on reset, otherwise advance on request.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            pc <= '0;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch/decode controller behind a registered-address, registered-data ROM.
// Waits out ROM latency, latches IR, decodes and drives one control cycle.
module instr_fetch_ctrl
    import instr_fetch_pkg::*;
#(
    parameter int ROM_LAT = 2,
    parameter int PC_W    = 7
) (
    input  logic                  Clk,
    input  logic                  Reset,
    instr_fetch_ctrl_if.master    bus
);

    localparam logic [1:0] LAST = 2'(ROM_LAT - 1);

    state_t     state;
    state_t     nxt;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic [6:0] ir;
    opcode_t    op;

    logic       w_en;
    logic [1:0] w_addr;
    logic [1:0] ra_addr;
    logic [1:0] rb_addr;
    logic       rf_s;
    alu_sel_t   alu_s;
    logic [3:0] d_addr;
    logic       d_wr;

    assign op = op_of(ir);

    pc_counter #(.PC_W(PC_W)) u_pc (
        .Clk   (Clk),
        .Reset (Reset),
        .inc   (state == S_FETCH),
        .pc    (bus.PC)
    );

    // State, wait counter and instruction register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_INIT;
            cnt   <= '0;
            ir    <= '0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
            if (state == S_FETCH) begin
                ir <= bus.Instr;
            end
        end
    end

    // Next state: ROM_LAT wait cycles, fetch, decode, one execute cycle.
    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        unique case (state)
            S_INIT: begin
                nxt     = S_WAIT;
                cnt_nxt = '0;
            end
            S_WAIT: begin
                if (cnt == LAST) begin
                    nxt     = S_FETCH;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: nxt = (op == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                nxt     = S_WAIT;
                cnt_nxt = '0;
            end
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_INIT;
        endcase
    end

    // Moore control outputs from state and IR.
    always_comb begin
        w_en    = 1'b0;
        w_addr  = '0;
        ra_addr = '0;
        rb_addr = '0;
        rf_s    = 1'b0;
        alu_s   = ALU_PASS;
        d_addr  = '0;
        d_wr    = 1'b0;
        unique case (state)
            S_DECODE: begin
                ra_addr = ir[RD_HI -: 2];
                rb_addr = ir[RS_HI -: 2];
            end
            S_EXEC: begin
                unique case (op)
                    OP_LOAD: begin
                        w_en   = 1'b1;
                        rf_s   = 1'b1;
                        w_addr = ir[RD_HI -: 2];
                        d_addr = {2'b00, ir[RS_HI -: 2]};
                    end
                    OP_STORE: begin
                        d_wr    = 1'b1;
                        d_addr  = {2'b00, ir[RS_HI -: 2]};
                        ra_addr = ir[RD_HI -: 2];
                    end
                    OP_ADD, OP_SUB: begin
                        ra_addr = ir[RD_HI -: 2];
                        rb_addr = ir[RS_HI -: 2];
                        alu_s   = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
                        w_en    = 1'b1;
                        w_addr  = ir[RD_HI -: 2];
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.IR         = ir;
    assign bus.RF_W_en    = w_en;
    assign bus.RF_W_addr  = w_addr;
    assign bus.RF_Ra_addr = ra_addr;
    assign bus.RF_Rb_addr = rb_addr;
    assign bus.RF_s       = rf_s;
    assign bus.ALU_s      = alu_s;
    assign bus.D_Addr     = d_addr;
    assign bus.D_Wr       = d_wr;
    assign bus.Halted     = (state == S_HALT);
    assign bus.State      = state;

endmodule
